// File: rtl/mig_ui_responder.sv
// -----------------------------------------------------------------------------
// mig_ui_responder
//
// Controller-side emulation of the 7-series MIG user (app) interface. It takes
// commands and write data from an initiator and serves reads from a small
// on-chip backing store. Used for DDR3-less bring-up and for simulating app
// initiators without the MIG IP. It drops in where mig_7series_0 would sit.
//
// Optional build macro:
//   MIG_UI_BACKPRESSURE_EN - a 16-bit LFSR (seed 16'hACE1) stalls app_rdy and
//                            app_wdf_rdy about one cycle in four, so that
//                            initiator retry logic gets exercised.
//
// Ports:
//   clk                  UI clock
//   sys_rst              asynchronous reset, active-high
//   app_addr             command address; index = app_addr[DEPTH_LOG2+2:3]
//   app_cmd              3'b000 write, 3'b001 read, others flagged as errors
//   app_en / app_rdy     command valid / command accept
//   app_wdf_data/_mask   write beat and byte mask (1 = byte not written)
//   app_wdf_wren/_end    write beat valid / last beat (must match wren)
//   app_wdf_rdy          write beat accept
//   app_rd_data          read data, RD_LATENCY cycles after read accept
//   app_rd_data_valid    read data valid (single-cycle pulse per read)
//   app_rd_data_end      same as app_rd_data_valid
//   init_calib_complete  calibration-done emulation
//   proto_err            sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module mig_ui_responder #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 6,
  parameter int RD_LATENCY = 4,
  parameter int CAL_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    proto_err
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int CAL_W      = $clog2(CAL_CYCLES + 2);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // ---------------------------------------------------------------------------
  // Calibration emulation
  // ---------------------------------------------------------------------------
  logic [CAL_W-1:0] cal_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
    end else if (cal_cnt != CAL_W'(CAL_CYCLES)) begin
      cal_cnt <= cal_cnt + 1'b1;
    end else begin
      init_calib_complete <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional pseudo-random backpressure
  // ---------------------------------------------------------------------------
  logic bp_stall;

`ifdef MIG_UI_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_stall = (lfsr[1:0] == 2'b00);
`else
  assign bp_stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_empty, fifo_full;
  logic       wr_pending;
  logic [DEPTH_LOG2-1:0] wr_pend_idx;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic       wdf_push, cmd_acc, data_avail;

  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_full  = fifo_cnt[2];

  assign app_rdy     = init_calib_complete & ~wr_pending & ~bp_stall;
  assign app_wdf_rdy = init_calib_complete & ~fifo_full  & ~bp_stall;

  assign wdf_push   = app_wdf_wren & app_wdf_rdy;
  assign cmd_acc    = app_en & app_rdy;
  // A beat pushed into an empty FIFO is usable in the same cycle (bypass).
  assign data_avail = ~fifo_empty | wdf_push;

  // Only the index bits select a store entry; the rest alias.
  assign addr_idx = app_addr[DEPTH_LOG2+2:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

  // ---------------------------------------------------------------------------
  // Write-data FIFO (depth 4, data + mask)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [MASK_WIDTH-1:0] fifo_mask [4];
  logic [DATA_WIDTH-1:0] head_data;
  logic [MASK_WIDTH-1:0] head_mask;

  assign head_data = fifo_empty ? app_wdf_data : fifo_data[rd_ptr];
  assign head_mask = fifo_empty ? app_wdf_mask : fifo_mask[rd_ptr];

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic                  commit_en;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic                  fifo_pop;
  logic                  set_pending;
  logic                  rd_acc;
  logic                  bad_cmd;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    commit_en   = 1'b0;
    commit_idx  = addr_idx;
    fifo_pop    = 1'b0;
    set_pending = 1'b0;
    rd_acc      = 1'b0;
    bad_cmd     = 1'b0;

    if (wr_pending) begin
      // app_rdy is low here, so no new command can be accepted alongside.
      if (wdf_push) begin
        commit_en  = 1'b1;
        commit_idx = wr_pend_idx;
        fifo_pop   = 1'b1;
      end
    end else if (cmd_acc) begin
      case (app_cmd)
        CMD_WRITE: begin
          if (data_avail) begin
            commit_en = 1'b1;
            fifo_pop  = 1'b1;
          end else begin
            set_pending = 1'b1;
          end
        end
        CMD_READ: rd_acc  = 1'b1;
        default:  bad_cmd = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wdf_push) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({wdf_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: data storage arrays carry no reset; the pointers and counters that
  // qualify them are reset, and the backing store must survive reset.
  always_ff @(posedge clk) begin
    if (wdf_push) begin
      fifo_data[wr_ptr] <= app_wdf_data;
      fifo_mask[wr_ptr] <= app_wdf_mask;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_pending  <= 1'b0;
      wr_pend_idx <= '0;
    end else if (set_pending) begin
      wr_pending  <= 1'b1;
      wr_pend_idx <= addr_idx;
    end else if (wr_pending && wdf_push) begin
      wr_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst)                             proto_err <= 1'b0;
    else if (bad_cmd | (wdf_push & ~app_wdf_end)) proto_err <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Backing store: byte-masked write, combinational read at accept
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] store [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (commit_en) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!head_mask[b]) store[commit_idx][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
  end

  // A write committed in the previous cycle is already in the store here,
  // which gives read-after-write ordering with no forwarding path.
  assign rd_word = store[addr_idx];

  // ---------------------------------------------------------------------------
  // Read pipeline, RD_LATENCY stages, no backpressure
  // ---------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] rd_vld;
  logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_vld[0] <= rd_acc;
      if (rd_acc) rd_pipe[0] <= rd_word;
    end
  end

  assign app_rd_data       = rd_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_ui_responder.sv
// -----------------------------------------------------------------------------
// tb_mig_ui_responder
//
// Self-checking bench for mig_ui_responder (default build). A transaction-level
// reference model pairs write commands with write beats in arrival order,
// applies byte-masked writes to a shadow store, and schedules expected read
// returns. Directed steps cover calibration, bypass and late-data writes, byte
// masking, aliasing, FIFO fill, protocol errors and reset mid-read; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_mig_ui_responder;

  localparam int AW    = 28;
  localparam int DW    = 512;
  localparam int MW    = DW / 8;
  localparam int DL    = 6;
  localparam int DEPTH = 1 << DL;
  localparam int RL    = 4;
  localparam int CC    = 16;

  logic          clk;
  logic          sys_rst;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;
  logic          proto_err;

  mig_ui_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .RD_LATENCY(RL),
    .CAL_CYCLES(CC)
  ) dut (
    .clk                 (clk),
    .sys_rst             (sys_rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .proto_err           (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  int            total;
  int            bad;
  int            cyc;
  int            since_rst;
  logic [DW-1:0] ref_mem [DEPTH];
  int            wq[$];
  logic [DW-1:0] bq_data[$];
  logic [MW-1:0] bq_mask[$];
  rd_exp_t       rq[$];
  bit            ref_proto;
  bit            acc_q;
  bit            push_q;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a / 8) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Oldest unmatched write command takes the oldest unmatched beat.
  task automatic pair_writes();
    int            idx;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    while (wq.size() > 0 && bq_data.size() > 0) begin
      idx = wq.pop_front();
      d   = bq_data.pop_front();
      m   = bq_mask.pop_front();
      for (int b = 0; b < MW; b++)
        if (!m[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // One clock: record the handshakes seen before the edge, advance the model,
  // then compare every output just after the edge.
  task automatic tick();
    bit acc, push, cal;
    acc  = (app_en === 1'b1) && (app_rdy === 1'b1);
    push = (app_wdf_wren === 1'b1) && (app_wdf_rdy === 1'b1);
    if (push) begin
      bq_data.push_back(app_wdf_data);
      bq_mask.push_back(app_wdf_mask);
      if (app_wdf_end !== 1'b1) ref_proto = 1'b1;
    end
    if (acc) begin
      if (app_cmd == 3'b000)      wq.push_back(idx_of(app_addr));
      else if (app_cmd != 3'b001) ref_proto = 1'b1;
    end
    pair_writes();
    if (acc && app_cmd == 3'b001) rq.push_back('{cyc + RL, ref_mem[idx_of(app_addr)]});
    acc_q  = acc;
    push_q = push;

    @(posedge clk);
    #1;
    cyc++;
    since_rst++;

    cal = (since_rst >= CC + 1);
    check("calib", init_calib_complete, cal);
    check("app_rdy", app_rdy, cal && wq.size() == 0);
    check("app_wdf_rdy", app_wdf_rdy, cal && bq_data.size() < 4);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rd_valid", app_rd_data_valid, 1'b1);
      check("rd_end", app_rd_data_end, 1'b1);
      check("rd_data", app_rd_data, rq[0].data);
      void'(rq.pop_front());
    end else begin
      check("rd_valid_idle", app_rd_data_valid, 1'b0);
      check("rd_end_idle", app_rd_data_end, 1'b0);
    end
    check("proto_err", proto_err, ref_proto);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    sys_rst      = 1'b1;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    #2;
    check("rst_calib", init_calib_complete, 1'b0);
    check("rst_app_rdy", app_rdy, 1'b0);
    check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    check("rst_rd_valid", app_rd_data_valid, 1'b0);
    check("rst_rd_end", app_rd_data_end, 1'b0);
    check("rst_rd_data", app_rd_data, '0);
    check("rst_proto_err", proto_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    wq.delete();
    bq_data.delete();
    bq_mask.delete();
    rq.delete();
    ref_proto = 1'b0;
    since_rst = 0;
  endtask

  task automatic issue_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    int n;
    app_en   = 1'b1;
    app_cmd  = cmd;
    app_addr = addr;
    n = 0;
    acc_q = 1'b0;
    while (!acc_q && n < 50) begin
      tick();
      n++;
    end
    app_en = 1'b0;
    check("cmd_accept_timeout", acc_q, 1'b1);
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
    int n;
    app_wdf_wren = 1'b1;
    app_wdf_end  = e;
    app_wdf_data = d;
    app_wdf_mask = m;
    n = 0;
    push_q = 1'b0;
    while (!push_q && n < 50) begin
      tick();
      n++;
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    check("beat_accept_timeout", push_q, 1'b1);
  endtask

  task automatic wr_with_data(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [MW-1:0] m);
    bit c_done, d_done;
    int n;
    app_en       = 1'b1;
    app_cmd      = 3'b000;
    app_addr     = addr;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    c_done = 1'b0;
    d_done = 1'b0;
    n = 0;
    while (!(c_done && d_done) && n < 50) begin
      tick();
      if (acc_q)  begin c_done = 1'b1; app_en = 1'b0; end
      if (push_q) begin d_done = 1'b1; app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
      n++;
    end
    check("write_timeout", c_done && d_done, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] ff_low0;
    logic [MW-1:0] keep_byte0;
    int            n_rand;

    total = 0; bad = 0; cyc = 0; since_rst = 0;
    ref_proto = 1'b0; acc_q = 1'b0; push_q = 1'b0;
    sys_rst = 1'b1;
    app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset and calibration timeline (checked every cycle inside tick).
    do_reset();
    idle(CC + 3);

    // Give every store entry a known value.
    for (int i = 0; i < DEPTH; i++) wr_with_data(AW'(i * 8), rand_word(), '0);

    // Write with simultaneous data, then read back after RD_LATENCY.
    wr_with_data(28'h0000000, 512'h508050FF, '0);
    issue_cmd(3'b001, 28'h0000000);
    idle(RL - 1);
    check("tp_rd_valid_0", app_rd_data_valid, 1'b1);
    check("tp_rd_data_0", app_rd_data, 512'h508050FF);

    // Write command ahead of its data.
    issue_cmd(3'b000, 28'h0000040);
    idle(2);
    check("tp_rdy_low_pending", app_rdy, 1'b0);
    push_beat(512'hDEADBEEF, '0, 1'b1);
    check("tp_rdy_back", app_rdy, 1'b1);
    issue_cmd(3'b001, 28'h0000040);
    idle(RL - 1);
    check("tp_rd_data_40", app_rd_data, 512'hDEADBEEF);

    // Byte mask and address aliasing.
    ff_low0    = {{(DW - 8){1'b1}}, 8'h00};
    keep_byte0 = {{(MW - 1){1'b1}}, 1'b0};
    wr_with_data(28'h0000008, {DW{1'b1}}, '0);
    wr_with_data(28'h0000008, '0, keep_byte0);
    issue_cmd(3'b001, 28'h0000008);
    idle(RL - 1);
    check("tp_mask_data", app_rd_data, ff_low0);
    issue_cmd(3'b001, 28'h0000008 + (28'd64 << 3));
    idle(RL - 1);
    check("tp_alias_data", app_rd_data, ff_low0);

    // Fill the write FIFO without commands, then drain it with commands.
    for (int i = 0; i < 4; i++) push_beat(rand_word(), '0, 1'b1);
    check("tp_fifo_full", app_wdf_rdy, 1'b0);
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = rand_word();
    app_wdf_mask = '0;
    idle(2);
    check("tp_fifth_held", push_q, 1'b0);
    app_en   = 1'b1;
    app_cmd  = 3'b000;
    app_addr = 28'h0000100;
    tick();
    app_en = 1'b0;
    check("tp_wdf_rdy_rise", app_wdf_rdy, 1'b1);
    tick();
    check("tp_fifth_pushed", push_q, 1'b1);
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    for (int i = 0; i < 4; i++) issue_cmd(3'b000, AW'(28'h0000108 + i * 8));
    for (int i = 0; i < 5; i++) issue_cmd(3'b001, AW'(28'h0000100 + i * 8));
    idle(RL + 1);

    // Protocol errors, then reset with a read in flight.
    issue_cmd(3'b010, 28'h0000000);
    idle(RL + 1);
    check("tp_proto_bad_cmd", proto_err, 1'b1);
    push_beat(rand_word(), '0, 1'b0);
    issue_cmd(3'b000, 28'h0000018);
    check("tp_proto_sticky", proto_err, 1'b1);
    issue_cmd(3'b001, 28'h0000018);
    tick();
    do_reset();
    idle(CC + RL + 3);
    check("tp_proto_cleared", proto_err, 1'b0);

    // Random traffic; the initiator holds each request until it is taken.
    n_rand = 0;
    acc_q  = 1'b0;
    push_q = 1'b0;
    while (n_rand < 400) begin
      if (!app_en || acc_q) begin
        app_en   = ($urandom_range(0, 2) != 0);
        app_cmd  = 3'($urandom_range(0, 1));
        app_addr = AW'($urandom);
      end
      if (!app_wdf_wren || push_q) begin
        app_wdf_wren = ($urandom_range(0, 1) != 0);
        app_wdf_end  = app_wdf_wren;
        app_wdf_data = rand_word();
        app_wdf_mask = ($urandom_range(0, 1) != 0) ? MW'({$urandom, $urandom}) : '0;
      end
      tick();
      n_rand++;
    end
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    idle(RL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
Synthesizable responder for the 7-series MIG user (app) interface. It emulates the controller side of the interface: it accepts commands and write data from an initiator and returns read data from a small on-chip backing store. It is used for DDR3-less bring-up and for simulating app-interface initiators without the MIG IP. It sits where mig_7series_0 would sit and presents the same app_* signal set.

Parameters:
ADDR_WIDTH, 28, width of app_addr
DATA_WIDTH, 512, app data width (4:1 mode, one beat per BL8 burst)
DEPTH_LOG2, 6, log2 of backing-store entries (each entry is DATA_WIDTH bits)
RD_LATENCY, 4, cycles from read command accept to app_rd_data_valid (minimum 1)
CAL_CYCLES, 16, cycles after reset release before init_calib_complete rises

Ports:
clk  in  1  UI clock
sys_rst  in  1  asynchronous reset, active-high
app_addr  in  ADDR_WIDTH  command address (8-word burst aligned)
app_cmd  in  3  000 = write, 001 = read
app_en  in  1  command valid
app_rdy  out  1  command accept
app_wdf_data  in  DATA_WIDTH  write data
app_wdf_mask  in  DATA_WIDTH/8  byte mask; 1 = byte not written
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat; must equal app_wdf_wren
app_wdf_rdy  out  1  write data accept
app_rd_data  out  DATA_WIDTH  read data
app_rd_data_valid  out  1  read data valid
app_rd_data_end  out  1  equals app_rd_data_valid
init_calib_complete  out  1  calibration-done emulation
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset is asynchronous, clock is clk. All outputs reset to 0. The write-data FIFO, pending-write register and read pipeline are flushed. The calibration counter restarts. Backing-store contents are retained (not reset).
- Calibration: a counter counts CAL_CYCLES clocks after reset deasserts. init_calib_complete rises on the following cycle and stays high until the next reset. While it is low, app_rdy and app_wdf_rdy are 0.
- Write-data FIFO:
  - Depth 4, holding data and mask.
  - app_wdf_rdy = calib & !full.
  - A beat is pushed when app_wdf_wren & app_wdf_rdy.
  - wren=1 with end=0 sets proto_err; the beat is still pushed.
  - Data may arrive before, with, or after its command.
- Command handshake:
  - A command is accepted when app_en & app_rdy.
  - app_rdy = calib & !wr_pending (& !bp_stall when the optional feature is enabled).
  - app_en without app_rdy is held by the initiator. Dropping it before accept sets no error.
- Write command:
  - If FIFO data is available (already stored, or being pushed this cycle with the FIFO empty — bypass), commit in the accept cycle. The store entry is updated on the next edge.
  - Otherwise latch the address into wr_pending. app_rdy stays low until a beat arrives; the write commits in the cycle the beat is pushed, and app_rdy returns high the next cycle.
- Index = app_addr[DEPTH_LOG2+2:3]. Higher bits alias (wrap-around). app_addr[2:0] is ignored.
- Byte lane b is written only if mask[b] = 0.
- Read command: the store is read at accept. Data appears RD_LATENCY cycles later with app_rd_data_valid = app_rd_data_end = 1 for exactly 1 cycle.
- Ordering:
  - Commands are strictly in order. A read accepted the cycle after a write to the same index returns the new data.
  - A read accepted in the same cycle a pending write commits is impossible, because app_rdy is low then.
- Back-to-back reads are accepted every cycle with no bubble. Valid pulses follow at the same spacing.
- Read pipeline: a shift register RD_LATENCY deep (valid and data). No backpressure on read data.
- Any other app_cmd value: the command is accepted and ignored, and proto_err is set.
- proto_err is cleared only by reset.
- Reset mid-operation: in-flight reads are discarded (no valid pulse), pending writes are dropped, and the store is unchanged.

Optional Feature:
MIG_UI_BACKPRESSURE_EN:
- When defined, a 16-bit LFSR (seed 16'hACE1, advancing every clk after reset) drives bp_stall = (lfsr[1:0] == 2'b00). This pseudo-randomly deasserts app_rdy about one cycle in four, and app_wdf_rdy with the same stall. The purpose is to exercise initiator retry.
- When undefined, bp_stall = 0, and app_rdy/app_wdf_rdy follow only calibration, pending and full conditions.

Test Plan:
- Reset, then wait → init_calib_complete=0 for CAL_CYCLES(16) cycles, then 1; app_rdy=app_wdf_rdy=0 before, 1 after; all outputs 0 during reset.
- Write cmd addr 0x0000000 with simultaneous data 0x508050FF, mask 0; then read addr 0x0000000 → app_rd_data=0x508050FF, valid/end high exactly 4 cycles after read accept.
- Write cmd addr 0x40 with no data → app_rdy=0 until data 0xDEADBEEF is pushed 3 cycles later, app_rdy high the next cycle; read 0x40 returns 0xDEADBEEF.
- Prefill 0xFF..FF at addr 0x8; write 0x00..00 with mask = all ones except byte 0 → read returns 0xFF..FF00; then read addr 0x8+(64<<3) (alias) → same value.
- 4 data beats with no commands → app_wdf_rdy falls after the 4th; a 5th wren is held; issue 1 write cmd → app_wdf_rdy rises.
- app_cmd=3'b010 accepted → proto_err=1, no read data; wren=1/end=0 → proto_err stays 1; sys_rst mid-read → no valid pulse, proto_err=0.
